// File: rtl/rbus_packet_tx_if.sv
// rbus_packet_tx_if: local write port and rbus output port of rbus_packet_tx
interface rbus_packet_tx_if;
  logic        l_stb, l_sof, l_eof, l_rdy;
  logic [71:0] l_data;
  logic        o_stb, o_sof, ff_err;
  logic [71:0] o_data;
  logic [1:0]  o_rdy, o_rdyE;
  modport master (
    input  l_stb, l_sof, l_eof, l_data, o_rdy, o_rdyE,
    output l_rdy, o_stb, o_sof, o_data, ff_err
  );
  modport slave (
    output l_stb, l_sof, l_eof, l_data, o_rdy, o_rdyE,
    input  l_rdy, o_stb, o_sof, o_data, ff_err
  );
endinterface

// File: rtl/rbus_packet_tx.sv
// rbus_packet_tx: buffers local packets in a FIFO and launches them as rbus frames.
// Define RBUS_TX_RDYE_WAIT_EN to launch only into an empty downstream lane.
module rbus_packet_tx #(
  parameter int DEPTH  = 32,
  parameter int MAXLEN = 16
) (
  input logic clk,
  input logic rst,
  rbus_packet_tx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAXLEN + 1) + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [LW-1:0] MAXL = LW'(MAXLEN);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [73:0] mem [DEPTH];
  logic [73:0] head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] used_q, used_d, pkt_cnt_q, pkt_cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [71:0] o_data_q, o_data_d;
  logic in_pkt_q, in_pkt_d, o_stb_q, o_stb_d, o_sof_q, o_sof_d;
  logic l_rdy_q, ff_err_q, err, push, pop, lane_ok, unused_bits;
  assign head = mem[rd_ptr_q];
  assign push = bus.l_stb & l_rdy_q;
`ifdef RBUS_TX_RDYE_WAIT_EN
  assign lane_ok = bus.o_rdy[head[71]] & bus.o_rdyE[head[71]];
  assign unused_bits = head[72];
`else
  assign lane_ok = bus.o_rdy[head[71]];
  assign unused_bits = head[72] ^ (^bus.o_rdyE);
`endif
  // launch needs an idle output cycle so frames are always separated by one gap
  assign pop = (state_q == SEND) | (!o_stb_q & (pkt_cnt_q != '0) & lane_ok);
  always_comb begin
    state_d   = pop ? (head[73] ? IDLE : SEND) : state_q;
    o_stb_d   = pop;
    o_sof_d   = pop & (state_q == IDLE);
    o_data_d  = pop ? head[71:0] : o_data_q;
    used_d    = used_q + (AW+1)'(push) - (AW+1)'(pop);
    pkt_cnt_d = pkt_cnt_q + (AW+1)'(push & bus.l_eof) - (AW+1)'(pop & head[73]);
    len_d     = bus.l_sof ? LW'(1) : (len_q > MAXL ? len_q : len_q + LW'(1));
    in_pkt_d  = push ? !bus.l_eof : in_pkt_q;
    err       = (bus.l_stb & !l_rdy_q) |
                (push & ((bus.l_sof == in_pkt_q) | (len_d > MAXL)));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      used_q    <= '0;
      pkt_cnt_q <= '0;
      len_q     <= '0;
      in_pkt_q  <= 1'b0;
      o_stb_q   <= 1'b0;
      o_sof_q   <= 1'b0;
      o_data_q  <= '0;
      l_rdy_q   <= 1'b0;
      ff_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_q + AW'(push);
      rd_ptr_q  <= rd_ptr_q + AW'(pop);
      used_q    <= used_d;
      pkt_cnt_q <= pkt_cnt_d;
      len_q     <= push ? len_d : len_q;
      in_pkt_q  <= in_pkt_d;
      o_stb_q   <= o_stb_d;
      o_sof_q   <= o_sof_d;
      o_data_q  <= o_data_d;
      l_rdy_q   <= used_d < FULL;
      ff_err_q  <= ff_err_q | err;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.l_eof, bus.l_sof, bus.l_data};
  end
  assign bus.o_stb  = o_stb_q;
  assign bus.o_sof  = o_sof_q;
  assign bus.o_data = o_data_q;
  assign bus.l_rdy  = l_rdy_q;
  assign bus.ff_err = ff_err_q;
endmodule

// File: tb/tb_rbus_packet_tx.sv
// tb_rbus_packet_tx: directed stimulus with a packet-queue reference model checked every cycle
module tb_rbus_packet_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  rbus_packet_tx_if bus();
  rbus_packet_tx #(.DEPTH(32), .MAXLEN(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  int stb_cnt = 0, sof_cnt = 0, hdr_cycle = 0, last_stb = 0, prev_stb = 0;
  int eof_cycle = 0, rdy_cycle = 0;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic bit lane_ok(input logic lane);
`ifdef RBUS_TX_RDYE_WAIT_EN
    return bus.o_rdy[lane] & bus.o_rdyE[lane];
`else
    return bus.o_rdy[lane];
`endif
  endfunction
  // model: FIFO of words, frame = head words up to eof, launch needs a complete packet and an idle cycle
  logic [73:0] q[$];
  int m_used, m_pkts, m_len, rem;
  bit m_rdy, m_err, in_pkt, exp_stb, exp_sof;
  logic [71:0] exp_data;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        q.delete();
        m_used = 0; m_pkts = 0; m_len = 0; rem = 0;
        m_rdy = 1'b0; m_err = 1'b0; in_pkt = 1'b0;
        exp_stb = 1'b0; exp_sof = 1'b0; exp_data = '0;
      end else begin
        exp_sof = 1'b0;
        if (rem == 0 && !exp_stb && m_pkts > 0 && lane_ok(q[0][71])) begin
          rem = 1;
          while (!q[rem-1][73]) rem++;
          exp_sof = 1'b1;
        end
        exp_stb = rem > 0;
        if (exp_stb) begin
          exp_data = q[0][71:0];
          if (q[0][73]) m_pkts--;
          void'(q.pop_front());
          rem--;
          m_used--;
        end
        if (bus.l_stb) begin
          if (m_rdy) begin
            q.push_back({bus.l_eof, bus.l_sof, bus.l_data});
            m_used++;
            if (bus.l_eof) m_pkts++;
            m_len = bus.l_sof ? 1 : m_len + 1;
            if (bus.l_sof == in_pkt || m_len > 16) m_err = 1'b1;
            in_pkt = !bus.l_eof;
          end else m_err = 1'b1;
        end
        m_rdy = m_used < 32;
      end
      @(negedge clk);
      chk("o_stb", 72'(bus.o_stb), 72'(exp_stb));
      chk("o_sof", 72'(bus.o_sof), 72'(exp_sof));
      chk("o_data", bus.o_data, exp_data);
      chk("l_rdy", 72'(bus.l_rdy), 72'(m_rdy));
      chk("ff_err", 72'(bus.ff_err), 72'(m_err));
      if (bus.o_stb) begin
        stb_cnt++;
        prev_stb = last_stb;
        last_stb = cyc + 1;
        if (bus.o_sof) begin
          sof_cnt++;
          hdr_cycle = cyc + 1;
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put(input logic sof, input logic eof, input logic [71:0] d);
    bus.l_stb = 1'b1; bus.l_sof = sof; bus.l_eof = eof; bus.l_data = d;
    if (eof) eof_cycle = cyc + 1;
    idle(1);
    bus.l_stb = 1'b0; bus.l_sof = 1'b0; bus.l_eof = 1'b0;
  endtask
  task automatic pkt(input logic lane, input int n, input int base);
    for (int i = 0; i < n; i++) put(i == 0, i == n - 1, {lane, 71'(base + i)});
  endtask
  task automatic clear_counts();
    stb_cnt = 0; sof_cnt = 0; hdr_cycle = 0; last_stb = 0; prev_stb = 0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    chk("reset o_stb", 72'(bus.o_stb), 72'(0));
    chk("reset l_rdy", 72'(bus.l_rdy), 72'(0));
    chk("reset ff_err", 72'(bus.ff_err), 72'(0));
    rst = 1'b1;
    idle(1);
    chk("l_rdy after reset", 72'(bus.l_rdy), 72'(1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    bus.l_stb = 1'b0; bus.l_sof = 1'b0; bus.l_eof = 1'b0; bus.l_data = '0;
    bus.o_rdy = 2'b00; bus.o_rdyE = 2'b11;
    idle(3);
    chk("reset o_sof", 72'(bus.o_sof), 72'(0));
    chk("reset o_data", bus.o_data, 72'(0));
    do_reset();
    // 3-word lane-0 packet
    bus.o_rdy = 2'b01;
    clear_counts();
    pkt(1'b0, 3, 'h100);
    idle(8);
    chk("t1 stb cycles", 72'(stb_cnt), 72'(3));
    chk("t1 sof count", 72'(sof_cnt), 72'(1));
    chk("t1 header latency", 72'(hdr_cycle - eof_cycle), 72'(2));
    chk("t1 ff_err", 72'(bus.ff_err), 72'(0));
    // lane-1 packet held back until o_rdy[1]
    clear_counts();
    pkt(1'b1, 2, 'h200);
    idle(10);
    chk("t2 no launch while lane busy", 72'(stb_cnt), 72'(0));
    bus.o_rdy = 2'b11;
    rdy_cycle = cyc + 1;
    idle(6);
    chk("t2 launch delay", 72'(hdr_cycle - rdy_cycle), 72'(1));
    chk("t2 stb cycles", 72'(stb_cnt), 72'(2));
    // back-to-back single-word packets
    clear_counts();
    pkt(1'b0, 1, 'h300);
    pkt(1'b0, 1, 'h301);
    idle(6);
    chk("t3 pulses", 72'(stb_cnt), 72'(2));
    chk("t3 pulse spacing", 72'(last_stb - prev_stb), 72'(2));
    chk("t3 last data", bus.o_data, 72'h301);
`ifdef RBUS_TX_RDYE_WAIT_EN
    clear_counts();
    bus.o_rdyE = 2'b00;
    pkt(1'b0, 2, 'h400);
    idle(6);
    chk("rdyE no launch", 72'(stb_cnt), 72'(0));
    bus.o_rdyE = 2'b01;
    rdy_cycle = cyc + 1;
    idle(4);
    chk("rdyE launch delay", 72'(hdr_cycle - rdy_cycle), 72'(1));
    bus.o_rdyE = 2'b11;
    idle(2);
`endif
    // sof inside a packet
    put(1'b1, 1'b0, 72'h500);
    put(1'b1, 1'b1, 72'h501);
    chk("mid-packet sof ff_err", 72'(bus.ff_err), 72'(1));
    idle(5);
    do_reset();
    // 17-word packet exceeds MAXLEN
    for (int i = 0; i < 17; i++) begin
      put(i == 0, i == 16, 72'(12'h600 + i));
      if (i == 15) chk("16 words ff_err", 72'(bus.ff_err), 72'(0));
    end
    chk("17 words ff_err", 72'(bus.ff_err), 72'(1));
    idle(22);
    do_reset();
    // fill FIFO, overflow, then reset mid-frame
    bus.o_rdy = 2'b00;
    for (int p = 0; p < 8; p++) pkt(1'b0, 4, 'h700 + 16 * p);
    chk("full l_rdy", 72'(bus.l_rdy), 72'(0));
    chk("full ff_err", 72'(bus.ff_err), 72'(0));
    put(1'b1, 1'b1, 72'h7ff);
    chk("overflow ff_err", 72'(bus.ff_err), 72'(1));
    idle(5);
    chk("overflow ff_err sticky", 72'(bus.ff_err), 72'(1));
    clear_counts();
    bus.o_rdy = 2'b11;
    idle(2);
    chk("frame in progress", 72'(stb_cnt), 72'(1));
    rst = 1'b0;
    idle(1);
    chk("mid-frame reset o_stb", 72'(bus.o_stb), 72'(0));
    chk("mid-frame reset ff_err", 72'(bus.ff_err), 72'(0));
    idle(1);
    rst = 1'b1;
    clear_counts();
    idle(10);
    chk("discarded after reset", 72'(stb_cnt), 72'(0));
    chk("l_rdy after drain reset", 72'(bus.l_rdy), 72'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
